// File: rtl/bit_sel_pkg.sv
// Shared definitions for the per-port bit selection (write) and deselection (read) stages.
// Width encodings, bus geometry and the buffered request entry.
package bit_sel_pkg;

  localparam int DATA_W   = 20;
  localparam int ADDR_W   = 16;
  localparam int LANE_LSB = 0;
  localparam int LANE_MSB = 4;

  localparam logic [2:0] CONFIG_NONE  = 3'd0;
  localparam logic [2:0] CONFIG_1BIT  = 3'd1;
  localparam logic [2:0] CONFIG_2BIT  = 3'd2;
  localparam logic [2:0] CONFIG_5BIT  = 3'd3;
  localparam logic [2:0] CONFIG_10BIT = 3'd4;
  localparam logic [2:0] CONFIG_20BIT = 3'd5;
  localparam logic [2:0] CONFIG_40BIT = 3'd6;
  localparam logic [2:0] CONFIG_80BIT = 3'd7;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] mask;
  } entry_t;

  // Bits carried by this port; zero marks an unusable configuration.
  function automatic logic [4:0] cfg_width(input logic [2:0] cfg);
    case (cfg)
      CONFIG_1BIT:  return 5'd1;
      CONFIG_2BIT:  return 5'd2;
      CONFIG_5BIT:  return 5'd5;
      CONFIG_10BIT: return 5'd10;
      CONFIG_20BIT,
      CONFIG_40BIT,
      CONFIG_80BIT: return 5'd20;
      default:      return 5'd0;
    endcase
  endfunction

  // Wide modes split across both macro ports, so this port always owns the full lane.
  function automatic logic cfg_full(input logic [2:0] cfg);
    return (cfg == CONFIG_40BIT) || (cfg == CONFIG_80BIT);
  endfunction

endpackage

// File: rtl/bit_selection_lane_gen.sv
// Combinational lane decode: config + bit offset + data -> legality, write mask, replicated data.
module bit_selection_lane_gen
  import bit_sel_pkg::*;
(
  input  logic [2:0]                 cfg,
  input  logic [LANE_MSB-LANE_LSB:0] offset,
  input  logic [DATA_W-1:0]          data,
  output logic                       cfg_ok,
  output logic                       lane_ok,
  output logic [DATA_W-1:0]          mask,
  output logic [DATA_W-1:0]          rep_data
);

  logic [4:0]        width;
  logic              full;
  logic [DATA_W-1:0] base;

  always_comb begin
    width    = cfg_width(cfg);
    full     = cfg_full(cfg);
    cfg_ok   = (width != 5'd0);
    lane_ok  = 1'b0;
    base     = '0;
    rep_data = '0;
    case (width)
      5'd1: begin
        lane_ok  = (offset < 5'd20);
        base     = 20'h00001;
        rep_data = {20{data[0]}};
      end
      5'd2: begin
        lane_ok  = ~offset[0] && (offset < 5'd20);
        base     = 20'h00003;
        rep_data = {10{data[1:0]}};
      end
      5'd5: begin
        lane_ok  = offset inside {5'd0, 5'd5, 5'd10, 5'd15};
        base     = 20'h0001F;
        rep_data = {4{data[4:0]}};
      end
      5'd10: begin
        lane_ok  = offset inside {5'd0, 5'd10};
        base     = 20'h003FF;
        rep_data = {2{data[9:0]}};
      end
      5'd20: begin
        lane_ok  = full || (offset == 5'd0);
        base     = 20'hFFFFF;
        rep_data = data;
      end
      default: begin
        lane_ok  = 1'b0;
        base     = '0;
        rep_data = '0;
      end
    endcase
    mask = full ? base : (base << offset);
  end

endmodule

// File: rtl/bit_selection_ram_port.sv
// Write-side lane placement for one 20-bit RAM macro port, behind a 2-entry skid buffer.
// Latency 1; req_ready_o is registered and drops only while the skid entry is occupied.
module bit_selection_ram_port
  import bit_sel_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        input_config_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wrdata_i,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wrdata_o,
  output logic [DATA_W-1:0] ram_bitmask_o,
  input  logic              ram_ready_i,
  output logic              err_o,
  input  logic              err_clr_i
);

  logic              cfg_ok;
  logic              lane_ok;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] lane_data;

  bit_selection_lane_gen u_lane_gen (
    .cfg      (input_config_i),
    .offset   (req_addr_i[LANE_MSB:LANE_LSB]),
    .data     (req_wrdata_i),
    .cfg_ok   (cfg_ok),
    .lane_ok  (lane_ok),
    .mask     (lane_mask),
    .rep_data (lane_data)
  );

  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  entry_t new_entry;
  logic   out_vld_q, out_vld_d;
  logic   skid_vld_q, skid_vld_d;
  logic   ready_q;
  logic   err_q;

  logic   accept;
  logic   legal;
  logic   push;
  logic   out_free;

  assign accept   = req_valid_i && ready_q;
  // Reads ignore the lane entirely; only a bad config can reject them.
  assign legal    = cfg_ok && (!req_we_i || lane_ok);
  assign push     = accept && legal;
  assign out_free = !out_vld_q || ram_ready_i;

  always_comb begin
    new_entry      = '0;
    new_entry.we   = req_we_i;
    new_entry.addr = req_addr_i;
    if (req_we_i) begin
      new_entry.data = lane_data;
      new_entry.mask = lane_mask;
    end
  end

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (out_free) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_d     = '0;
        skid_vld_d = 1'b0;
        if (push) begin
          skid_d     = new_entry;
          skid_vld_d = 1'b1;
        end
      end else if (push) begin
        out_d     = new_entry;
        out_vld_d = 1'b1;
      end else begin
        out_d     = '0;
        out_vld_d = 1'b0;
      end
    end else if (push) begin
      skid_d     = new_entry;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      ready_q    <= !skid_vld_d;
    end
  end

  // A new error outranks a clear arriving in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (accept && !legal) begin
      err_q <= 1'b1;
    end else if (err_clr_i) begin
      err_q <= 1'b0;
    end
  end

  assign req_ready_o   = ready_q;
  assign ram_en_o      = out_vld_q;
  assign ram_we_o      = out_q.we;
  assign ram_addr_o    = out_q.addr;
  assign ram_wrdata_o  = out_q.data;
  assign ram_bitmask_o = out_q.mask;
  assign err_o         = err_q;

endmodule

// File: tb/tb_bit_selection_ram_port.sv
// Randomized and directed bench for bit_selection_ram_port against a queue-based reference model.
module tb_bit_selection_ram_port;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  cfg = 3'd0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [19:0] req_wrdata = '0;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [19:0] ram_wrdata;
  logic [19:0] ram_bitmask;
  logic        ram_ready = 1'b1;
  logic        err;
  logic        err_clr = 1'b0;

  bit_selection_ram_port dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .input_config_i (cfg),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_addr_i     (req_addr),
    .req_wrdata_i   (req_wrdata),
    .ram_en_o       (ram_en),
    .ram_we_o       (ram_we),
    .ram_addr_o     (ram_addr),
    .ram_wrdata_o   (ram_wrdata),
    .ram_bitmask_o  (ram_bitmask),
    .ram_ready_i    (ram_ready),
    .err_o          (err),
    .err_clr_i      (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [19:0] data;
    logic [19:0] mask;
  } exp_t;

  exp_t q[$];
  logic m_rdy = 1'b0;
  logic m_err = 1'b0;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int width_of(input logic [2:0] c);
    int tab [8] = '{0, 1, 2, 5, 10, 20, 20, 20};
    return tab[c];
  endfunction

  // Expected macro-side entry from the lane rules, using plain arithmetic.
  function automatic logic model(input logic [2:0] c, input logic we, input logic [15:0] a,
                                 input logic [19:0] d, output exp_t e);
    int  w;
    int  l;
    logic [19:0] ones;
    w = width_of(c);
    l = int'(a[4:0]);
    e = '0;
    e.we = we;
    e.addr = a;
    if (w == 0) return 1'b0;
    if (c >= 3'd6) l = 0;
    else if (we && ((l % w) != 0 || l + w > 20)) return 1'b0;
    if (we) begin
      ones = 20'((64'd1 << w) - 1);
      e.mask = ones << l;
      for (int i = 0; i < 20; i++) e.data[i] = d[i % w];
    end
    return 1'b1;
  endfunction

  task automatic compare_outputs();
    check("ready", 32'(req_ready), 32'(m_rdy));
    check("en", 32'(ram_en), 32'(q.size() > 0));
    check("err", 32'(err), 32'(m_err));
    if (q.size() > 0) begin
      check("we", 32'(ram_we), 32'(q[0].we));
      check("addr", 32'(ram_addr), 32'(q[0].addr));
      check("wrdata", 32'(ram_wrdata), 32'(q[0].data));
      check("mask", 32'(ram_bitmask), 32'(q[0].mask));
    end
  endtask

  task automatic step(input logic v, input logic we, input logic [15:0] a, input logic [19:0] d,
                      input logic rr, input logic clr, output logic acc);
    exp_t e;
    logic ok;
    logic drain;
    @(negedge clk);
    compare_outputs();
    req_valid = v; req_we = we; req_addr = a; req_wrdata = d;
    ram_ready = rr; err_clr = clr;
    @(posedge clk);
    drain = (q.size() > 0) && rr;
    acc = v && m_rdy;
    if (drain) void'(q.pop_front());
    ok = model(cfg, we, a, d, e);
    if (acc && ok) q.push_back(e);
    if (acc && !ok) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    m_rdy = (q.size() <= 1);
  endtask

  task automatic send(input logic we, input logic [15:0] a, input logic [19:0] d, input logic rr);
    logic acc;
    for (int n = 0; n < 10; n++) begin
      step(1'b1, we, a, d, rr, 1'b0, acc);
      if (acc) return;
    end
    check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, 20'h0, 1'b1, 1'b0, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; err_clr = 1'b0;
    @(posedge clk);
    q.delete(); m_err = 1'b0; m_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_en", 32'(ram_en), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_wrdata", 32'(ram_wrdata), 32'd0);
    check("rst_mask", 32'(ram_bitmask), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    m_rdy = 1'b1;
  endtask

  function automatic logic [15:0] rand_addr(input logic [2:0] c);
    int w;
    logic [4:0] l;
    w = width_of(c);
    if (w == 0 || $urandom_range(0, 3) == 0) l = 5'($urandom_range(0, 31));
    else l = 5'(w * $urandom_range(0, 20 / w - 1));
    return {11'($urandom), l};
  endfunction

  initial begin
    logic acc;
    logic pv, pwe;
    logic [15:0] pa;
    logic [19:0] pd;

    do_reset();

    cfg = 3'd3;
    send(1'b1, {11'h2A5, 5'd10}, 20'h00016, 1'b1);
    idle(3);

    cfg = 3'd1;
    for (int l = 0; l < 20; l++)
      step(1'b1, 1'b1, {11'($urandom), 5'(l)}, 20'($urandom), 1'b1, 1'b0, acc);
    idle(3);

    cfg = 3'd2;
    step(1'b1, 1'b1, 16'h0100, 20'h00001, 1'b0, 1'b0, acc);
    step(1'b1, 1'b1, 16'h0202, 20'h00002, 1'b0, 1'b0, acc);
    step(1'b1, 1'b1, 16'h0304, 20'h00003, 1'b0, 1'b0, acc);
    send(1'b1, 16'h0304, 20'h00003, 1'b1);
    idle(4);

    cfg = 3'd4;
    send(1'b1, 16'h0405, 20'h3FF, 1'b1);
    idle(2);
    step(1'b0, 1'b0, 16'h0, 20'h0, 1'b1, 1'b1, acc);
    idle(2);

    cfg = 3'd7;
    send(1'b1, 16'h0507, 20'hABCDE, 1'b1);
    send(1'b0, 16'h0607, 20'h12345, 1'b1);
    idle(3);

    cfg = 3'd0;
    send(1'b0, 16'h0700, 20'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 20'h0, 1'b1, 1'b1, acc);
    idle(2);

    for (int b = 0; b < 16; b++) begin
      cfg = 3'($urandom_range(0, 7));
      pv = 1'b0; pwe = 1'b0; pa = '0; pd = '0;
      for (int c = 0; c < 40; c++) begin
        if (!pv && $urandom_range(0, 2) != 0) begin
          pv = 1'b1; pwe = 1'($urandom); pa = rand_addr(cfg); pd = 20'($urandom);
        end
        step(pv, pwe, pa, pd, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), acc);
        if (acc) pv = 1'b0;
      end
      if (pv) send(pwe, pa, pd, 1'b1);
      idle(4);
    end

    cfg = 3'd1;
    step(1'b1, 1'b1, 16'h0800, 20'h1, 1'b0, 1'b0, acc);
    step(1'b1, 1'b1, 16'h0801, 20'h0, 1'b0, 1'b0, acc);
    step(1'b1, 1'b1, 16'h0802, 20'h1, 1'b0, 1'b0, acc);
    do_reset();
    send(1'b1, 16'h0903, 20'h1, 1'b1);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bit_selection_ram_port.md
Name: bit_selection_ram_port

Overview:
- Write-side counterpart of the per-port read bit-deselection stage. Sits directly upstream of one 20-bit RAM-macro port (A or B).
- Accepts narrow-width write requests and read requests through a valid/ready interface.
- For writes, replicates the data into the addressed bit lane and generates a per-bit write mask. For reads, forwards the address unchanged.
- Registers requests in a 2-entry skid buffer so that macro stalls do not break timing on the requester side.

Parameters:
- CONFIG_1BIT, 3'd1, 1-bit port mode
- CONFIG_2BIT, 3'd2, 2-bit port mode
- CONFIG_5BIT, 3'd3, 5-bit port mode
- CONFIG_10BIT, 3'd4, 10-bit port mode
- CONFIG_20BIT, 3'd5, 20-bit port mode
- CONFIG_40BIT, 3'd6, 40-bit mode (this port carries 20 bits, full lane)
- CONFIG_80BIT, 3'd7, 80-bit mode (this port carries 20 bits, full lane)

Ports:
- clk_i  in  1  port clock
- rst_i  in  1  synchronous reset, active-high
- input_config_i  in  3  static width config; may only change while idle
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  16  [15:5] word address, [4:0] bit offset of lane
- req_wrdata_i  in  20  right-aligned write data (low W bits used)
- ram_en_o  out  1  macro access strobe
- ram_we_o  out  1  macro write enable
- ram_addr_o  out  16  address to macro, also forwarded to the read deselection stage
- ram_wrdata_o  out  20  lane-placed write data
- ram_bitmask_o  out  20  per-bit write enable, 1 = write
- ram_ready_i  in  1  macro accepts the current output this cycle
- err_o  out  1  sticky: illegal config or lane
- err_clr_i  in  1  clears err_o

Behaviour:
- Reset values: req_ready_o=0 in the reset cycle, then 1. ram_en_o=0, ram_we_o=0, ram_addr_o=0, ram_wrdata_o=0, ram_bitmask_o=0, err_o=0. Both buffer entries are invalid.
- Width W per config: 1/2/5/10/20. CONFIG_40BIT and CONFIG_80BIT are treated as W=20.
- Lane offset L = req_addr_i[4:0].
- Legal lane: L mod W == 0 and L+W <= 20. For W=20 only L=0 is legal, except in 40/80 modes, where L is ignored.
- Write data placement: ram_wrdata_o = low W bits of req_wrdata_i replicated across all 20/W lanes, so every lane carries the data. Bits not covered by the mask are don't-care.
- Write mask: ram_bitmask_o = ((1<<W)-1) << L.
- Reads: ram_we_o=0, mask=0, data=0, address unchanged.
- Illegal config (3'd0) or illegal write lane:
  - The request is accepted and dropped; nothing is emitted.
  - err_o is set on the cycle after acceptance.
  - Illegal lane on a read: forwarded normally, no error.
- Pipeline: an accepted legal request appears on the ram_* outputs on the next clk_i edge (latency 1) when the output register is empty or being drained.
- Output register holds while ram_en_o=1 and ram_ready_i=0. Outputs are stable until consumed.
- Skid buffer, 2 entries (output register + skid register):
  - req_ready_o is registered: 1 iff the skid entry is empty.
  - When the output is stalled, an incoming accepted request goes to the skid entry.
  - When the output drains, the skid entry moves to the output register.
  - Ordering is strictly FIFO.
- Simultaneous accept and drain with an empty skid entry: the new request goes directly to the output register. No bubble; sustained throughput is 1 request per cycle.
- ram_en_o drops to 0 the cycle after the last entry drains, if there is no new request.
- err_clr_i and a new error in the same cycle: set wins.
- Reset mid-operation: both entries are discarded, outputs return to reset values, no partial write is issued.
- Config is sampled at acceptance; each buffered entry carries its computed mask.

Decomposition:
- Shared package (bit_sel_pkg): CONFIG_* encodings, DATA_W=20, ADDR_W=16, LANE_LSB=0, LANE_MSB=4, and a width-lookup function config->W. The read deselection stage reuses the same package.
- One natural sub-module: bit_selection_lane_gen. Combinational: config, offset, data -> W, legal, mask, replicated data. Instantiated once on the input side.

Test Plan:
- CONFIG_5BIT, write L=10, data=5'b10110, ram_ready_i=1 -> next cycle: en=1, we=1, mask=20'h07C00, wrdata[14:10]=5'b10110, addr unchanged.
- CONFIG_1BIT, writes at L=0..19 back-to-back, ram_ready_i=1 -> 20 consecutive outputs, mask=1<<L, req_ready_o stays 1, no bubbles.
- CONFIG_2BIT, hold ram_ready_i=0 for 3 cycles while sending 3 requests -> first two accepted, req_ready_o=0 on the third. After release, outputs appear in order, and the third is accepted one cycle after release.
- CONFIG_10BIT, write L=5 -> nothing emitted, err_o=1 next cycle. err_clr_i pulse -> err_o=0.
- CONFIG_80BIT, write L=7, data=20'hABCDE -> mask=20'hFFFFF, wrdata=20'hABCDE, no error. Read request -> we=0, mask=0.
- rst_i asserted with both entries full -> next cycle all outputs at reset values. After reset, the first request appears with latency 1.
